fetch_unit: RTL and testbench
=============================

# fetch_unit

Multi-cycle instruction fetch stage for the Y86-64 SEQ datapath. Given a PC, it reads the instruction one byte at a time from a byte-wide instruction memory port, splits it into icode/ifun/rA/rB/valC, and computes valP. It feeds decode/execute and, through valP/valC, the PC-update stage. It starts a new fetch on each `start` pulse and signals completion with a one-cycle `done`.

## Interface
- `MEM_SIZE`, 1024: instruction memory size in bytes. Any address ≥ MEM_SIZE is an error.
- `clk` in 1: single clock, all state changes on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: pulse that begins a fetch at `PC`. Honoured only when idle.
- `PC` in 64: fetch address, sampled in the cycle `start` is accepted.
- `mem_req` out 1: byte read request.
- `mem_addr` out 64: byte address, stable while `mem_req` is high.
- `mem_ack` in 1: the byte is returned on `mem_rdata` in the same cycle.
- `mem_rdata` in 8: returned byte.
- `busy` out 1: a fetch is in progress.
- `done` out 1: one-cycle completion pulse.
- `icode`, `ifun` out 4 each: instruction fields.
- `rA`, `rB` out 4 each: register specifiers. Value is 0xF when the instruction has no register byte.
- `valC` out 64: little-endian constant. Value is 0 when the instruction has no constant.
- `valP` out 64: PC + instruction length.
- `instr_valid` out 1: 0 if icode > 0xB.
- `imem_error` out 1: an address was out of range.
- `halt` out 1: icode == 0 on a valid, error-free fetch.

## Operation
- **Reset:** state IDLE. `mem_req`, `busy`, `done`, `imem_error`, `halt` = 0. `icode`, `ifun`, `valC`, `valP` = 0. `rA`, `rB` = 0xF. `instr_valid` = 1. `mem_addr` = 0. Reset mid-fetch abandons the fetch immediately; no `done` is produced.
- **FSM states:** IDLE → BYTE0 → (REGS) → (CONST ×8) → FIN → IDLE.
- **IDLE:**
  - On `start`, latch PC into base, clear the byte index, go to BYTE0.
  - Also clear `rA`/`rB` to 0xF and `valC` to 0.
- **Address check:** in every fetch state the current address is checked before `mem_req` is raised. If the address is ≥ MEM_SIZE, do not request; set `imem_error` = 1, `valP` = base, `halt` = 0, and go to FIN.
- **BYTE0:**
  - On ack, `icode` = rdata[7:4] and `ifun` = rdata[3:0].
  - Instruction length is set by icode: 0, 1, 9 → 1 byte; 2, 6, A, B → 2 bytes; 7, 8 → 9 bytes; 3, 4, 5 → 10 bytes.
  - icode > 0xB: `instr_valid` = 0, length 1, go to FIN.
  - Length 1 → FIN. Icodes 7, 8 → CONST. All others with length > 1 → REGS.
- **REGS:** on ack, `rA` = rdata[7:4] and `rB` = rdata[3:0]. Length 2 → FIN, otherwise → CONST.
- **CONST:**
  - Reads 8 bytes at consecutive addresses.
  - Byte k goes to `valC`[8k+7:8k], so the first byte is the LSB.
  - After the 8th ack, go to FIN.
- **FIN:**
  - `valP` = base + length. The sum is 64-bit and wraps modulo 2^64.
  - `halt` = (icode == 0) & `instr_valid` & ~`imem_error`.
  - Pulse `done`, return to IDLE.
- **Output hold:** outputs hold their values until the next accepted `start`. At that point `imem_error`, `halt` and `instr_valid` reset to 0, 0, 1.
- **`start` while busy:** ignored, not queued.
- **`start` in the FIN cycle:** ignored. The earliest new start is the cycle after `done`.

## Timing
- **Memory handshake:**
  - `mem_req` rises in the cycle after the state is entered.
  - The request holds until `mem_ack` is sampled high.
  - A byte is consumed only on a cycle with `mem_req` & `mem_ack`. Ack without req is ignored.
  - The address advances on the following edge.
- **Latency with zero-wait memory** (ack in every request cycle), counted from the `start` edge to `done` high:
  - 1-byte instructions: 2 cycles.
  - 2-byte: 3 cycles.
  - 9-byte: 10 cycles.
  - 10-byte: 11 cycles.
  - Each wait cycle on an ack adds 1 cycle.
- `busy` is high from the cycle after the start edge through FIN inclusive.
- `done` is high for exactly 1 cycle. All outputs are valid in that cycle and remain valid afterwards.

## Test plan
- **nop:** memory[0x10] = 0x10, `start` with PC = 0x10 → icode 1, ifun 0, rA/rB 0xF, valC 0, valP 0x11, `done` 2 cycles after start.
- **irmovq:** bytes 30 F3 EF CD AB 89 67 45 23 01 at 0x20 → rA 0xF, rB 3, valC 0x0123456789ABCDEF, valP 0x2A, exactly 10 `mem_req`&`mem_ack` transfers.
- **jXX with wait states:** jle (71) at 0x40 with dest 0x0000000000000100, ack delayed 2 cycles on every byte → ifun 1, valC 0x100, valP 0x49, `mem_addr` stable while waiting, `done` at start+28.
- **Invalid and halt:** byte 0xC0 → `instr_valid` 0, valP PC+1, `halt` 0. Byte 0x00 → `halt` 1, valP PC+1.
- **Range error:** MEM_SIZE = 1024, call (80) at 0x3FC → 4 bytes fetched, no request to 0x400, `imem_error` 1, valP 0x3FC, `halt` 0.
- **Reset and busy:** `rst` during the 5th CONST byte → next cycle IDLE, all outputs at reset values, no `done`. Also, `start` pulsed mid-fetch → ignored, and the original fetch completes unchanged.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: multi-cycle Y86-64 instruction fetch over a byte-wide memory port.
// Requests are registered; each address is range-checked on the edge that would raise mem_req.
module fetch_unit #(
    parameter logic [63:0] MEM_SIZE = 64'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] PC,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        busy,
    output logic        done,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic        instr_valid,
    output logic        imem_error,
    output logic        halt
);
    typedef enum logic [2:0] {IDLE, BYTE0, REGS, CONST, FIN} state_t;

    state_t      state, nxt;
    logic [63:0] base, naddr;
    logic [3:0]  idx, len, nlen, nidx;
    logic [2:0]  k;
    logic        last;

    function automatic logic [3:0] len_of(input logic [3:0] c);
        return (c inside {4'h2, 4'h6, 4'hA, 4'hB}) ? 4'd2 :
               (c inside {4'h7, 4'h8})             ? 4'd9 :
               (c inside {4'h3, 4'h4, 4'h5})       ? 4'd10 : 4'd1;
    endfunction

    always_comb begin
        nlen  = (state == BYTE0) ? len_of(mem_rdata[7:4]) : len;
        nidx  = idx + 4'd1;
        naddr = mem_addr + 64'd1;
        last  = nidx == nlen;
        nxt   = (state == BYTE0 && !(mem_rdata[7:4] inside {4'h7, 4'h8})) ? REGS : CONST;
        // Constant byte position: after the opcode, and after the register byte when present
        k     = 3'(idx - ((len == 4'd9) ? 4'd1 : 4'd2));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            base        <= '0;
            idx         <= '0;
            len         <= '0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            icode       <= '0;
            ifun        <= '0;
            rA          <= 4'hF;
            rB          <= 4'hF;
            valC        <= '0;
            valP        <= '0;
            instr_valid <= 1'b1;
            imem_error  <= 1'b0;
            halt        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    base        <= PC;
                    idx         <= '0;
                    mem_addr    <= PC;
                    rA          <= 4'hF;
                    rB          <= 4'hF;
                    valC        <= '0;
                    instr_valid <= 1'b1;
                    halt        <= 1'b0;
                    busy        <= 1'b1;
                    imem_error  <= PC >= MEM_SIZE;
                    if (PC >= MEM_SIZE) begin
                        valP  <= PC;
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        mem_req <= 1'b1;
                        state   <= BYTE0;
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: if (mem_req && mem_ack) begin
                    if (state == BYTE0) begin
                        icode       <= mem_rdata[7:4];
                        ifun        <= mem_rdata[3:0];
                        instr_valid <= mem_rdata[7:4] <= 4'hB;
                        halt        <= mem_rdata[7:4] == 4'h0;
                        len         <= nlen;
                    end else if (state == REGS) begin
                        rA <= mem_rdata[7:4];
                        rB <= mem_rdata[3:0];
                    end else begin
                        valC[{k, 3'b000} +: 8] <= mem_rdata;
                    end
                    idx <= nidx;
                    if (last || naddr >= MEM_SIZE) begin
                        mem_req    <= 1'b0;
                        done       <= 1'b1;
                        imem_error <= !last;
                        valP       <= last ? base + {60'd0, nlen} : base;
                        state      <= FIN;
                    end else begin
                        mem_addr <= naddr;
                        state    <= nxt;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed fetches against a byte-level instruction model with wait-state memory.
module tb_fetch_unit;
    logic        clk = 0, rst = 1, start = 0;
    logic [63:0] PC = '0;
    logic        mem_req, mem_ack, busy, done, instr_valid, imem_error, halt;
    logic [63:0] mem_addr, valC, valP;
    logic [7:0]  mem_rdata;
    logic [3:0]  icode, ifun, rA, rB;

    logic [7:0]  mem [0:1023];
    int          waits = 0, wcnt = 0, xfers = 0, cyc = 0, tests = 0, fails = 0;
    bit          oor = 0, unstable = 0, spurious = 0, armed = 0, prev_wait = 0;
    logic [63:0] prev_addr = '0;

    typedef struct {
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp;
        logic        valid, err, halt;
        int          xfers, lat;
    } exp_t;
    exp_t e;

    fetch_unit #(.MEM_SIZE(64'd1024)) dut (
        .clk(clk), .rst(rst), .start(start), .PC(PC),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
        .valC(valC), .valP(valP), .instr_valid(instr_valid), .imem_error(imem_error), .halt(halt)
    );

    always #5 clk = ~clk;

    assign mem_ack   = mem_req && wcnt >= waits;
    assign mem_rdata = mem[mem_addr[9:0]];

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        wcnt <= (!mem_req || mem_ack) ? 0 : wcnt + 1;
        if (start && !busy && !rst) begin
            xfers    <= 0;
            oor      <= 0;
            unstable <= 0;
        end else begin
            if (mem_req && mem_ack) xfers <= xfers + 1;
            if (mem_req && mem_addr >= 64'd1024) oor <= 1;
            if (prev_wait && mem_req && mem_addr != prev_addr) unstable <= 1;
        end
        prev_wait <= mem_req && !mem_ack;
        prev_addr <= mem_addr;
    end

    always @(negedge clk) if (done && !armed) spurious <= 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic put(input int a, input int n, input logic [79:0] bytes);
        for (int i = 0; i < n; i++) mem[a + i] = bytes[8*(n-1-i) +: 8];
    endtask

    // Walks the instruction byte by byte the way the ISA defines it
    function automatic exp_t model(input logic [63:0] pc, input int w);
        exp_t r;
        logic [7:0] b;
        bit regs, cst;
        int len;
        r = '{default: 0};
        r.ra = 4'hF;
        r.rb = 4'hF;
        b = mem[pc[9:0]];
        r.icode = b[7:4];
        r.ifun  = b[3:0];
        r.valid = b[7:4] <= 4'hB;
        regs = r.valid && (b[7:4] inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB});
        cst  = r.valid && (b[7:4] inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8});
        len  = 1 + int'(regs) + 8 * int'(cst);
        for (int i = 0; i < len; i++) begin
            logic [63:0] a;
            a = pc + 64'(i);
            if (a >= 64'd1024) begin
                r.err = 1;
                break;
            end
            b = mem[a[9:0]];
            r.xfers++;
            if (regs && i == 1) {r.ra, r.rb} = b;
            else if (i > 0) r.valc[8*(i-1-int'(regs)) +: 8] = b;
        end
        r.valp = r.err ? pc : pc + 64'(len);
        r.halt = r.icode == 4'h0 && r.valid && !r.err;
        r.lat  = r.xfers * (w + 1) + 1;
        return r;
    endfunction

    task automatic compare(input string t);
        chk({t, "_icode"}, 64'(icode), 64'(e.icode));
        chk({t, "_ifun"}, 64'(ifun), 64'(e.ifun));
        chk({t, "_rA"}, 64'(rA), 64'(e.ra));
        chk({t, "_rB"}, 64'(rB), 64'(e.rb));
        chk({t, "_valC"}, valC, e.valc);
        chk({t, "_valP"}, valP, e.valp);
        chk({t, "_valid"}, 64'(instr_valid), 64'(e.valid));
        chk({t, "_err"}, 64'(imem_error), 64'(e.err));
        chk({t, "_halt"}, 64'(halt), 64'(e.halt));
    endtask

    task automatic chk_reset(input string t);
        chk({t, "_req"}, 64'(mem_req), 0);
        chk({t, "_busy"}, 64'(busy), 0);
        chk({t, "_done"}, 64'(done), 0);
        chk({t, "_err"}, 64'(imem_error), 0);
        chk({t, "_halt"}, 64'(halt), 0);
        chk({t, "_icode"}, 64'(icode), 0);
        chk({t, "_ifun"}, 64'(ifun), 0);
        chk({t, "_rA"}, 64'(rA), 64'hF);
        chk({t, "_rB"}, 64'(rB), 64'hF);
        chk({t, "_valC"}, valC, 0);
        chk({t, "_valP"}, valP, 0);
        chk({t, "_valid"}, 64'(instr_valid), 1);
        chk({t, "_addr"}, mem_addr, 0);
    endtask

    task automatic run(input string t, input logic [63:0] pc, input int w, input bit intr, output int lat);
        int sc, n;
        waits = w;
        e = model(pc, w);
        armed = 1;
        @(negedge clk);
        PC = pc;
        start = 1;
        sc = cyc;
        @(negedge clk);
        start = 0;
        n = 0;
        while (!done && n < 400) begin
            start = intr && n == 2;
            if (start) PC = 64'h10;
            @(negedge clk);
            n++;
        end
        start = 0;
        chk({t, "_done_seen"}, 64'(done), 1);
        lat = cyc - sc;
        chk({t, "_latency"}, 64'(lat), 64'(e.lat));
        chk({t, "_xfers"}, 64'(xfers), 64'(e.xfers));
        chk({t, "_no_oor_req"}, 64'(oor), 0);
        chk({t, "_addr_stable"}, 64'(unstable), 0);
        compare(t);
        PC = 64'h10;
        start = 1;
        @(negedge clk);
        start = 0;
        armed = 0;
        chk({t, "_fin_start_ignored"}, 64'(busy), 0);
        compare({t, "_hold"});
    endtask

    initial begin
        int lat, n;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        put('h10, 1, 80'h10);
        put('h20, 10, 80'h30F3EFCDAB8967452301);
        put('h40, 9, 80'h710001000000000000);
        put('h50, 1, 80'hC0);
        put('h60, 1, 80'h00);
        put('h70, 2, 80'h2012);
        put('h80, 10, 80'h50450807060504030201);
        put('h3FC, 4, 80'h80112233);

        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst = 0;

        run("nop", 64'h10, 0, 0, lat);
        chk("nop_valP_lit", valP, 64'h11);
        chk("nop_lat_lit", 64'(lat), 2);

        run("irmovq", 64'h20, 0, 0, lat);
        chk("irmovq_valC_lit", valC, 64'h0123456789ABCDEF);
        chk("irmovq_rB_lit", 64'(rB), 3);
        chk("irmovq_xfers_lit", 64'(xfers), 10);
        chk("irmovq_lat_lit", 64'(lat), 11);

        run("jle", 64'h40, 2, 0, lat);
        chk("jle_valC_lit", valC, 64'h100);
        chk("jle_valP_lit", valP, 64'h49);
        chk("jle_lat_lit", 64'(lat), 28);

        run("invalid", 64'h50, 0, 0, lat);
        chk("invalid_valid_lit", 64'(instr_valid), 0);
        chk("invalid_valP_lit", valP, 64'h51);

        run("halt", 64'h60, 1, 0, lat);
        chk("halt_halt_lit", 64'(halt), 1);
        chk("halt_valP_lit", valP, 64'h61);

        run("rrmovq", 64'h70, 1, 0, lat);
        chk("rrmovq_rArB_lit", 64'({rA, rB}), 64'h12);
        chk("rrmovq_lat_lit", 64'(lat), 5);

        run("range", 64'h3FC, 0, 0, lat);
        chk("range_err_lit", 64'(imem_error), 1);
        chk("range_valP_lit", valP, 64'h3FC);
        chk("range_xfers_lit", 64'(xfers), 4);

        waits = 0;
        @(negedge clk);
        PC = 64'h20;
        start = 1;
        @(negedge clk);
        start = 0;
        n = 0;
        while (xfers != 6 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("midrst_reached", 64'(xfers), 6);
        rst = 1;
        @(negedge clk);
        chk_reset("midrst");
        rst = 0;
        repeat (20) @(negedge clk);
        chk("midrst_no_done", 64'(spurious), 0);

        run("mrmovq_busy_start", 64'h80, 0, 1, lat);
        chk("mrmovq_valC_lit", valC, 64'h0102030405060708);
        chk("mrmovq_valP_lit", valP, 64'h8A);
        chk("no_spurious_done", 64'(spurious), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
